// File: rtl/sevenseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver_if
//   Bundles the digit-data inputs and the display outputs of
//   sevenseg_scan_driver.
//
//   Signals (NDIG = digit count):
//     bcd_in     [4*NDIG] packed BCD, digit i = bcd_in[4i+3:4i], digit 0 rightmost
//     dp_in      [NDIG]   decimal point request per digit, active high
//     load                capture strobe for bcd_in/dp_in
//     seg_n      [7]      segments {g,f,e,d,c,b,a}, active low
//     dp_n                decimal point, active low
//     an_n       [NDIG]   digit enables, active low, at most one low
//     frame_done          one-cycle pulse on wrap from digit NDIG-1 to 0
//
//   Modports:
//     master - the data source (BCD counters) that also observes the display
//     slave  - the scan driver itself
// -----------------------------------------------------------------------------
interface sevenseg_scan_driver_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] bcd_in;
  logic [NDIG-1:0]   dp_in;
  logic              load;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [NDIG-1:0]   an_n;
  logic              frame_done;

  modport master (
    output bcd_in, dp_in, load,
    input  seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  bcd_in, dp_in, load,
    output seg_n, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed driver for a common-anode multi-digit 7-segment display.
//   Latches NDIG packed BCD digits plus decimal points, scans them one digit
//   per SCAN_DIV clock cycles, decodes the selected digit to active-low
//   segments and drives one active-low anode. The first BLANK_CYC cycles of
//   every digit slot are an all-off guard interval that suppresses ghosting.
//   All display outputs are registered (1 cycle after the pc/idx state).
//
//   Parameters:
//     NDIG      digits scanned (2..8)
//     SCAN_DIV  clock cycles per digit slot (>= 2)
//     BLANK_CYC guard cycles at the start of each slot (0 <= BLANK_CYC < SCAN_DIV)
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   sevenseg_scan_driver_if.slave: bcd_in, dp_in, load in;
//           seg_n, dp_n, an_n, frame_done out
//
//   Optional feature:
//     SEVENSEG_LEADING_ZERO_BLANK_EN - when defined, digit i>0 shows all
//     segments off while digit i and every higher digit latch as 0. Its anode
//     still asserts on schedule and dp_n still follows its decimal point.
//     Digit 0 is never blanked. Undefined: leading zeros are displayed.
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sevenseg_scan_driver_if.slave bus
);

  localparam int unsigned PCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDW = (NDIG > 2) ? $clog2(NDIG) : 1;

  localparam logic [PCW-1:0] PC_LAST  = PCW'(SCAN_DIV - 1);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(NDIG - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PCW-1:0]    pc;       // position inside the current digit slot
  logic [IDW-1:0]    idx;      // digit currently being scanned
  logic [4*NDIG-1:0] dig_q;    // latched BCD digits
  logic [NDIG-1:0]   dp_q;     // latched decimal points

  // ---------------------------------------------------------------------------
  // Combinational slot decode
  // ---------------------------------------------------------------------------
  logic            pc_wrap;    // last cycle of the current slot
  logic            frame_wrap; // last cycle of the last slot of the frame
  logic            guard;      // current cycle is in the all-off interval
  logic [3:0]      cur_dig;
  logic            cur_dp;
  logic            cur_blank;
  logic [NDIG-1:0] zero_from;  // zero_from[i]: digits i..NDIG-1 all latch 0
  logic [6:0]      seg_d;
  logic            dp_d;
  logic [NDIG-1:0] an_d;
  logic            fd_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111; // non-BCD: dash (segment g only)
    endcase
    return s;
  endfunction

  assign pc_wrap    = (pc == PC_LAST);
  assign frame_wrap = pc_wrap && (idx == IDX_LAST);

  // A zero-length guard makes the compare constant, so it is elaborated away.
  generate
    if (BLANK_CYC == 0) begin : g_no_guard
      assign guard = 1'b0;
    end else begin : g_guard
      localparam logic [PCW-1:0] PC_BLANK = PCW'(BLANK_CYC);
      assign guard = (pc < PC_BLANK);
    end
  endgenerate

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // Suffix-AND from the most significant digit downwards.
  always_comb begin
    zero_from = '0;
    zero_from[NDIG-1] = (dig_q[4*NDIG-1 -: 4] == 4'd0);
    for (int unsigned k = 1; k < NDIG; k++) begin
      zero_from[NDIG-1-k] = zero_from[NDIG-k] && (dig_q[4*(NDIG-1-k) +: 4] == 4'd0);
    end
  end
`else
  assign zero_from = '0;
`endif

  // Select the active digit's data and build the one-hot anode pattern.
  always_comb begin
    cur_dig   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx == IDW'(i)) begin
        cur_dig   = dig_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_blank = (i != 0) && zero_from[i];
        an_d[i]   = 1'b0;
      end
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    fd_d  = frame_wrap;
    if (guard) begin
      an_d_guard_dummy: begin end
    end else begin
      seg_d = cur_blank ? SEG_OFF : decode(cur_dig);
      dp_d  = ~cur_dp;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, digit index and input latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= '0;
      idx <= '0;
    end else if (pc_wrap) begin
      pc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= '0;
      dp_q  <= '0;
    end else if (bus.load) begin
      dig_q <= bus.bcd_in;
      dp_q  <= bus.dp_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered display outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg_n      <= SEG_OFF;
      bus.dp_n       <= 1'b1;
      bus.an_n       <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg_n      <= seg_d;
      bus.dp_n       <= dp_d;
      bus.an_n       <= guard ? '1 : an_d;
      bus.frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Self-checking bench for sevenseg_scan_driver (NDIG=4, SCAN_DIV=4,
//   BLANK_CYC=1). The reference model derives slot position and digit index
//   from the number of edges since reset, and frame_done from that count
//   modulo the frame length. Honours SEVENSEG_LEADING_ZERO_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  localparam int unsigned NDIG      = 4;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLANK_CYC = 1;
  localparam int unsigned FRAME     = NDIG * SCAN_DIV;

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] DEC [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  logic clk = 1'b0;
  logic rst = 1'b1;

  sevenseg_scan_driver_if #(.NDIG(NDIG)) bus ();

  sevenseg_scan_driver #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [4*NDIG-1:0] m_bcd;
  logic [NDIG-1:0]   m_dp;
  int unsigned       m_n;      // edges since reset release
  int unsigned       m_pc, m_idx;
  bit                m_allz;
  logic [6:0]        e_seg;
  logic              e_dp;
  logic [NDIG-1:0]   e_an;
  logic              e_fd;

  task automatic m_reset();
    m_n   = 0;
    m_bcd = '0;
    m_dp  = '0;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_an  = '1;
    e_fd  = 1'b0;
  endtask

  task automatic m_step();
    m_pc  = m_n % SCAN_DIV;
    m_idx = (m_n / SCAN_DIV) % NDIG;
    if (m_pc < BLANK_CYC) begin
      e_an  = '1;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an        = '1;
      e_an[m_idx] = 1'b0;
      e_seg       = DEC[m_bcd[4*m_idx +: 4]];
      if (LZ && m_idx > 0) begin
        m_allz = 1'b1;
        for (int unsigned j = m_idx; j < NDIG; j++)
          if (m_bcd[4*j +: 4] != 4'd0) m_allz = 1'b0;
        if (m_allz) e_seg = 7'h7F;
      end
      e_dp = ~m_dp[m_idx];
    end
    m_n++;
    e_fd = ((m_n % FRAME) == 0);
    if (bus.load) begin
      m_bcd = bus.bcd_in;
      m_dp  = bus.dp_in;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("seg_n",      32'(bus.seg_n),      32'(e_seg));
      chk("an_n",       32'(bus.an_n),       32'(e_an));
      chk("dp_n",       32'(bus.dp_n),       32'(e_dp));
      chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
      chk("an_onehot",  32'($countones(~bus.an_n) <= 1), 32'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_an(input logic [NDIG-1:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(2*FRAME + 4); i++) begin
      @(negedge clk);
      if (bus.an_n === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_pulse(input logic [4*NDIG-1:0] b, input logic [NDIG-1:0] d);
    @(negedge clk);
    #1;
    bus.bcd_in = b;
    bus.dp_in  = d;
    bus.load   = 1'b1;
    @(negedge clk);
    #1 bus.load = 1'b0;
  endtask

  task automatic expect_digit(input string name, input logic [NDIG-1:0] an, input logic [31:0] seg);
    bit ok;
    wait_an(an, ok);
    chk({name, "_found"}, 32'(ok), 32'd1);
    chk(name, 32'(bus.seg_n), seg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [4*NDIG-1:0] rb;

    bus.bcd_in = 16'h1234;
    bus.dp_in  = 4'b0100;
    bus.load   = 1'b1;

    // Reset held for 3 cycles, released mid-cycle.
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus.seg_n), 32'h7F);
    chk("rst_an",  32'(bus.an_n),  32'hF);
    chk("rst_dp",  32'(bus.dp_n),  32'd1);
    chk("rst_fd",  32'(bus.frame_done), 32'd0);
    #1 rst = 1'b0;

    @(negedge clk);                      // edge 1: guard, latch captures 1234
    chk("e1_an", 32'(bus.an_n), 32'b1111);
    #1 bus.load = 1'b0;
    @(negedge clk);                      // edge 2
    chk("e2_an",  32'(bus.an_n),  32'b1110);
    chk("e2_seg", 32'(bus.seg_n), 32'b0011001);
    repeat (4) @(negedge clk);           // edge 6
    chk("e6_an",  32'(bus.an_n),  32'b1101);
    chk("e6_seg", 32'(bus.seg_n), 32'b0110000);
    repeat (3) @(negedge clk);           // edge 9: guard before digit 2
    chk("e9_an", 32'(bus.an_n), 32'b1111);
    chk("e9_dp", 32'(bus.dp_n), 32'd1);
    @(negedge clk);                      // edge 10
    chk("e10_an",  32'(bus.an_n),  32'b1011);
    chk("e10_seg", 32'(bus.seg_n), 32'b0100100);
    chk("e10_dp",  32'(bus.dp_n),  32'd0);
    repeat (4) @(negedge clk);           // edge 14
    chk("e14_an",  32'(bus.an_n),  32'b0111);
    chk("e14_seg", 32'(bus.seg_n), 32'b1111001);
    chk("e14_dp",  32'(bus.dp_n),  32'd1);
    @(negedge clk);                      // edge 15
    chk("e15_fd", 32'(bus.frame_done), 32'd0);
    @(negedge clk);                      // edge 16: wrap
    chk("e16_fd", 32'(bus.frame_done), 32'd1);
    @(negedge clk);
    chk("e17_fd", 32'(bus.frame_done), 32'd0);

    // Load held low: display must not follow bcd_in.
    #1 bus.bcd_in = 16'h9999;
    repeat (FRAME) @(negedge clk);
    expect_digit("hold_d0", 4'b1110, 32'b0011001);
    load_pulse(16'h9999, 4'b0000);
    expect_digit("load_d0", 4'b1110, 32'b0010000);

    // Invalid code shows a dash.
    load_pulse(16'h00A0, 4'b0000);
    expect_digit("inval_d1", 4'b1101, 32'b0111111);

    // Leading zeros.
    load_pulse(16'h0050, 4'b0000);
    expect_digit("lz_d3", 4'b0111, LZ ? 32'h7F : 32'b1000000);
    expect_digit("lz_d2", 4'b1011, LZ ? 32'h7F : 32'b1000000);
    expect_digit("lz_d1", 4'b1101, 32'b0010010);
    expect_digit("lz_d0", 4'b1110, 32'b1000000);

    // Randomized phase with occasional mid-cycle resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      for (int d = 0; d < int'(NDIG); d++)
        rb[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.bcd_in = rb;
      bus.dp_in  = NDIG'($urandom);
      bus.load   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        #1;
        chk("arst_seg", 32'(bus.seg_n), 32'h7F);
        chk("arst_an",  32'(bus.an_n),  32'hF);
        chk("arst_fd",  32'(bus.frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Time-multiplexed driver for a common-anode multi-digit 7-segment display, the stage directly downstream of the BCD counters. It latches NDIG packed BCD digits, scans them one at a time at a rate set by an internal prescaler, decodes each digit to active-low segment patterns, and drives active-low digit enables. A short all-off guard interval at each digit switch suppresses ghosting. All display outputs are registered.

## Interface
- NDIG, 4: number of digits scanned (2..8).
- SCAN_DIV, 100000: clock cycles each digit stays selected (≥ 2).
- BLANK_CYC, 1: guard cycles at the start of each slot with all anodes off (0 ≤ BLANK_CYC < SCAN_DIV).

- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- bcd_in  in  4*NDIG  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is least significant (rightmost).
- dp_in  in  NDIG  decimal point request per digit, active high.
- load  in  1  capture strobe for bcd_in/dp_in; tie high for continuous tracking.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- an_n  out  NDIG  digit enables, active low, at most one low.
- frame_done  out  1  one-cycle pulse when scanning wraps from digit NDIG-1 to 0.

## Operation
- Reset values: prescaler pc=0, digit index idx=0, latched digits and dps all 0, seg_n=7'h7F, dp_n=1, an_n=all ones, frame_done=0.
- Capture: on a clock edge with load=1, bcd_in and dp_in go to the digit/dp latches. load=0 holds the previous value.
- Prescaler: pc counts 0..SCAN_DIV-1.
  - When pc=SCAN_DIV-1: the next edge sets pc=0 and idx=(idx==NDIG-1)?0:idx+1.
  - frame_done is registered high for exactly the edge on which idx wraps NDIG-1→0.
- Slot output, registered from the current pc/idx/latches:
  - pc<BLANK_CYC: guard. an_n all ones, seg_n=7'h7F, dp_n=1.
  - Otherwise: an_n[idx]=0 and all other bits 1; seg_n=decode(digit idx); dp_n=~dp[idx].
- Decode, active low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Non-BCD codes 10..15 display a dash, 0111111 (segment g only).
- Reset mid-scan: all state returns to reset values immediately, without waiting for a clock. The scan restarts at digit 0 with a guard interval after rst is released.

## Timing
- Each digit slot lasts exactly SCAN_DIV cycles, of which BLANK_CYC are guard cycles; a full frame is NDIG*SCAN_DIV cycles.
- Output latency is 1 cycle from pc/idx state to seg_n/an_n/dp_n.
- Load-to-display latency is 2 edges when the target digit is active: a capture edge, then an output edge.
- If load coincides with a digit switch, the incoming digit is shown using the old latch contents for 1 cycle. That cycle falls in the guard interval whenever BLANK_CYC ≥ 1.
- With BLANK_CYC=0 there is no guard: an_n moves one-hot directly from one digit to the next.

## Configuration
- SEVENSEG_LEADING_ZERO_BLANK_EN defined: digit i>0 is blanked (seg_n=7'h7F, but its an_n still asserts on schedule) when digit i and every higher digit all latch as 0. Digit 0 is never blanked. dp_n still follows dp[i] on a blanked digit.
- Undefined: all digits are always decoded, so leading zeros are displayed.

## Test plan
- Reset: hold rst=1 for 3 cycles, releasing mid-cycle -> seg_n=7F, an_n=F, dp_n=1, frame_done=0 while in reset. First active an_n=1110 appears BLANK_CYC+1 edges after release.
- Scan order (NDIG=4, SCAN_DIV=4, BLANK_CYC=1, bcd_in=16'h1234 loaded once) -> an_n sequence 1111×1, 1110×3, 1111×1, 1101×3, ….
  - seg_n=0011001 (4) with an_n=1110; seg_n=0110000 (3) with an_n=1101; seg_n=0100100 (2) with an_n=1011; seg_n=1111001 (1) with an_n=0111.
  - frame_done pulses once every 16 cycles.
- Load hold: load=0 while bcd_in changes to 16'h9999 -> display unchanged. One-cycle load=1 -> digit 0 shows 0010000 on its next active slot.
- Invalid code: bcd_in=16'h00A0 -> digit 1 shows 0111111.
- Decimal point: dp_in=4'b0100 -> dp_n=0 only while an_n=1011 outside the guard cycles.
- Leading zeros: bcd_in=16'h0050 -> with the macro, digits 3 and 2 show seg_n=7F, digit 1 shows 5 and digit 0 shows 0. Without the macro, 1000000 is shown on digits 3 and 2.
